uart_cmd_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_phy.sv | 125 ++++++++++++
 rtl/uart_cmd_rx.sv | 121 ++++++++++++
 tb/tb_uart_cmd_rx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command receiver.
// ASCII constants, receiver/parser state encodings and a sizing helper.
package uart_pkg;

   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_t  = 8'h74;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   typedef enum logic {
      P_IDLE,
      P_DIG
   } p_state_t;

   // Bits needed to hold values 0..v-1 (at least 1).
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_phy.sv
// 8N1 UART receiver: 2-FF synchroniser plus bit-timing FSM.
// Ports: clk, rst (sync, active-high), rx (async line, idle high),
//        rx_byte (last good byte), rx_valid / frame_err (1-cycle pulses).
module uart_rx_phy
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = clog2(DIV);
   localparam logic [CW-1:0] FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

   logic          s1;
   logic          rxs;
   rx_state_t     st;
   rx_state_t     st_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [2:0]    bitn;
   logic [2:0]    bitn_n;
   logic [7:0]    sh;
   logic [7:0]    sh_n;
   logic [7:0]    byte_n;
   logic          vld_n;
   logic          fe_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1  <= 1'b1;
         rxs <= 1'b1;
      end else begin
         s1  <= rx;
         rxs <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         cnt       <= '0;
         bitn      <= '0;
         sh        <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         st        <= st_n;
         cnt       <= cnt_n;
         bitn      <= bitn_n;
         sh        <= sh_n;
         rx_byte   <= byte_n;
         rx_valid  <= vld_n;
         frame_err <= fe_n;
      end
   end

   always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      bitn_n = bitn;
      sh_n   = sh;
      byte_n = rx_byte;
      vld_n  = 1'b0;
      fe_n   = 1'b0;
      unique case (st)
         IDLE: begin
            if (!rxs) begin
               cnt_n  = '0;
               bitn_n = '0;
               st_n   = START;
            end
         end
         START: begin
            // Half a bit in: confirm the start bit is still low.
            if (cnt == HALF) begin
               cnt_n = '0;
               st_n  = rxs ? IDLE : DATA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (cnt == FULL) begin
               cnt_n  = '0;
               sh_n   = {rxs, sh[7:1]};
               bitn_n = bitn + 3'd1;
               if (bitn == 3'd7) st_n = STOP;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         STOP: begin
            if (cnt == FULL) begin
               cnt_n = '0;
               if (rxs) begin
                  byte_n = sh;
                  vld_n  = 1'b1;
                  st_n   = IDLE;
               end else begin
                  fe_n = 1'b1;
                  st_n = BREAK;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         BREAK: begin
            // Line held low past the stop bit: wait for idle.
            if (rxs) st_n = IDLE;
         end
         default: st_n = IDLE;
      endcase
   end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: decodes "T<1-3 digits><CR|LF>" into a threshold.
// Ports: clk, rst (sync, active-high), rx, rx_byte/rx_valid/frame_err
//        (raw receiver), threshold (cm), thresh_valid / cmd_err pulses.
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ       = 12000000,
   parameter int BAUD           = 9600,
   parameter int DEFAULT_THRESH = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   output logic        frame_err,
   output logic [15:0] threshold,
   output logic        thresh_valid,
   output logic        cmd_err
);

   p_state_t   ps;
   p_state_t   ps_n;
   logic [9:0] acc;
   logic [9:0] acc_n;
   logic [1:0] ndig;
   logic [1:0] ndig_n;
   logic [9:0] thr;
   logic [9:0] thr_n;
   logic       tv_n;
   logic       ce_n;
   logic       is_t;
   logic       is_dig;
   logic       is_term;

   uart_rx_phy #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_phy (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   assign is_t    = (rx_byte == CH_T) || (rx_byte == CH_t);
   assign is_dig  = (rx_byte >= CH_0) && (rx_byte <= CH_9);
   assign is_term = (rx_byte == CH_CR) || (rx_byte == CH_LF);
   assign threshold = {6'b0, thr};

   always_ff @(posedge clk) begin
      if (rst) begin
         ps           <= P_IDLE;
         acc          <= '0;
         ndig         <= '0;
         thr          <= 10'(DEFAULT_THRESH);
         thresh_valid <= 1'b0;
         cmd_err      <= 1'b0;
      end else begin
         ps           <= ps_n;
         acc          <= acc_n;
         ndig         <= ndig_n;
         thr          <= thr_n;
         thresh_valid <= tv_n;
         cmd_err      <= ce_n;
      end
   end

   always_comb begin
      ps_n   = ps;
      acc_n  = acc;
      ndig_n = ndig;
      thr_n  = thr;
      tv_n   = 1'b0;
      ce_n   = 1'b0;
      if (rx_valid) begin
         unique case (ps)
            P_IDLE: begin
               if (is_t) begin
                  acc_n  = '0;
                  ndig_n = '0;
                  ps_n   = P_DIG;
               end
            end
            P_DIG: begin
               if (is_dig) begin
                  // acc <= 99 here, so acc*10+9 fits in 10 bits.
                  if (ndig != 2'd3) begin
                     acc_n  = 10'(acc * 10'd10) + {6'b0, rx_byte[3:0]};
                     ndig_n = ndig + 2'd1;
                  end else begin
                     ce_n = 1'b1;
                     ps_n = P_IDLE;
                  end
               end else if (is_term) begin
                  if (ndig != 2'd0 && acc != 10'd0) begin
                     thr_n = acc;
                     tv_n  = 1'b1;
                  end else begin
                     ce_n = 1'b1;
                  end
                  ps_n = P_IDLE;
               end else if (is_t) begin
                  acc_n  = '0;
                  ndig_n = '0;
               end else begin
                  ce_n = 1'b1;
                  ps_n = P_IDLE;
               end
            end
            default: ps_n = P_IDLE;
         endcase
      end else if (frame_err && ps == P_DIG) begin
         ce_n = 1'b1;
         ps_n = P_IDLE;
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: a full-rate instance for line timing
// and a fast-baud instance for command parsing against a queue-based model.
module tb_uart_cmd_rx;

   localparam int DIV_S = 1250;
   localparam int DIV_F = 16;

   logic        clk;
   logic        rst;
   logic        rx_s;
   logic        rx_f;
   logic [7:0]  rx_byte_s;
   logic        rx_valid_s;
   logic        frame_err_s;
   logic [15:0] threshold_s;
   logic        thresh_valid_s;
   logic        cmd_err_s;
   logic [7:0]  rx_byte_f;
   logic        rx_valid_f;
   logic        frame_err_f;
   logic [15:0] threshold_f;
   logic        thresh_valid_f;
   logic        cmd_err_f;

   uart_cmd_rx u_full (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx_s),
      .rx_byte      (rx_byte_s),
      .rx_valid     (rx_valid_s),
      .frame_err    (frame_err_s),
      .threshold    (threshold_s),
      .thresh_valid (thresh_valid_s),
      .cmd_err      (cmd_err_s)
   );

   uart_cmd_rx #(
      .CLK_FREQ       (160000),
      .BAUD           (10000),
      .DEFAULT_THRESH (15)
   ) u_fast (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx_f),
      .rx_byte      (rx_byte_f),
      .rx_valid     (rx_valid_f),
      .frame_err    (frame_err_f),
      .threshold    (threshold_f),
      .thresh_valid (thresh_valid_f),
      .cmd_err      (cmd_err_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Monitors, sampled on the falling edge.
   int cyc = 0;
   int rv_n = 0, fe_n = 0, tv_n = 0, ce_n = 0, viol = 0;
   int last_rv = -10, last_fe = -10;
   logic prv_rv = 0, prv_fe = 0;
   logic [7:0] last_byte = 0;
   int srv_n = 0, sfe_n = 0, stv_n = 0, sce_n = 0, sviol = 0, srv_cyc = -1;
   logic sprv = 0;
   logic [7:0] sbyte = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      prv_rv <= rx_valid_f;
      prv_fe <= frame_err_f;
      if (rx_valid_f) begin
         rv_n <= rv_n + 1;
         last_rv <= cyc;
         last_byte <= rx_byte_f;
         if (prv_rv || frame_err_f) viol <= viol + 1;
      end
      if (frame_err_f) begin
         fe_n <= fe_n + 1;
         last_fe <= cyc;
         if (prv_fe) viol <= viol + 1;
      end
      if (thresh_valid_f) begin
         tv_n <= tv_n + 1;
         if (last_rv != cyc - 1 || cmd_err_f) viol <= viol + 1;
      end
      if (cmd_err_f) begin
         ce_n <= ce_n + 1;
         if (last_rv != cyc - 1 && last_fe != cyc - 1) viol <= viol + 1;
      end
   end

   always @(negedge clk) begin
      sprv <= rx_valid_s;
      if (rx_valid_s) begin
         srv_n <= srv_n + 1;
         srv_cyc <= cyc;
         sbyte <= rx_byte_s;
         if (sprv) sviol <= sviol + 1;
      end
      if (frame_err_s) sfe_n <= sfe_n + 1;
      if (thresh_valid_s) stv_n <= stv_n + 1;
      if (cmd_err_s) sce_n <= sce_n + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act,
                          input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drv(input bit sel, input logic v);
      if (sel) rx_s = v;
      else rx_f = v;
   endtask

   // One 8N1 frame; low_stop>0 holds the stop bit low that many bit times.
   task automatic send(input bit sel, input int div,
                       input logic [7:0] b, input int low_stop);
      drv(sel, 1'b0);
      clks(div);
      for (int i = 0; i < 8; i++) begin
         drv(sel, b[i]);
         clks(div);
      end
      if (low_stop == 0) begin
         drv(sel, 1'b1);
         clks(div);
      end else begin
         drv(sel, 1'b0);
         clks(div * low_stop);
         drv(sel, 1'b1);
         clks(div);
      end
   endtask

   // Reference model: pending command kept as a queue of digit values.
   bit m_in = 0;
   int m_dig[$];
   int m_thr = 15, m_ce = 0, m_tv = 0, m_rv = 0;

   task automatic m_byte(input logic [7:0] b);
      bit is_t, is_d, is_term;
      int v;
      is_t = (b == "T") || (b == "t");
      is_d = (b >= "0") && (b <= "9");
      is_term = (b == 8'h0D) || (b == 8'h0A);
      m_rv++;
      if (!m_in) begin
         if (is_t) begin
            m_in = 1;
            m_dig.delete();
         end
      end else if (is_t) begin
         m_dig.delete();
      end else if (is_d) begin
         if (m_dig.size() == 3) begin
            m_ce++;
            m_in = 0;
         end else begin
            m_dig.push_back(int'(b) - 48);
         end
      end else if (is_term) begin
         v = 0;
         foreach (m_dig[k]) v = v * 10 + m_dig[k];
         if (m_dig.size() > 0 && v > 0) begin
            m_thr = v;
            m_tv++;
         end else begin
            m_ce++;
         end
         m_in = 0;
      end else begin
         m_ce++;
         m_in = 0;
      end
   endtask

   task automatic m_ferr();
      if (m_in) begin
         m_ce++;
         m_in = 0;
      end
   endtask

   typedef struct {
      logic [63:0] s;
      int n;
      bit ferr;
      int thr;
      int ce;
      int tv;
   } row_t;

   row_t tbl[10];

   initial begin
      int t0, s0, lat, rv0, fe0, tv0, ce0, len, r;
      logic [7:0] b;

      tbl[0] = '{s: "T42\015",   n: 4, ferr: 0, thr: 42,  ce: 0, tv: 1};
      tbl[1] = '{s: "t7\012",    n: 3, ferr: 0, thr: 7,   ce: 0, tv: 1};
      tbl[2] = '{s: "T1234\015", n: 6, ferr: 0, thr: 7,   ce: 1, tv: 0};
      tbl[3] = '{s: "T\015",     n: 2, ferr: 0, thr: 7,   ce: 1, tv: 0};
      tbl[4] = '{s: "T0\015",    n: 3, ferr: 0, thr: 7,   ce: 1, tv: 0};
      tbl[5] = '{s: "TX",        n: 2, ferr: 0, thr: 7,   ce: 1, tv: 0};
      tbl[6] = '{s: "T5",        n: 2, ferr: 1, thr: 7,   ce: 1, tv: 0};
      tbl[7] = '{s: "T9T25\015", n: 6, ferr: 0, thr: 25,  ce: 0, tv: 1};
      tbl[8] = '{s: "T999\012",  n: 5, ferr: 0, thr: 999, ce: 0, tv: 1};
      tbl[9] = '{s: "T007\015",  n: 5, ferr: 0, thr: 7,   ce: 0, tv: 1};

      rst = 1'b1;
      rx_s = 1'b1;
      rx_f = 1'b1;
      clks(4);
      rst = 1'b0;

      // Idle line after reset.
      clks(20000);
      chk("reset_thr_full", int'(threshold_s), 15);
      chk("reset_thr_fast", int'(threshold_f), 15);
      chk("reset_rx_byte", int'(rx_byte_f), 0);
      chk("idle_pulses_full", srv_n + sfe_n + stv_n + sce_n, 0);
      chk("idle_pulses_fast", rv_n + fe_n + tv_n + ce_n, 0);

      // 0xA5 at full rate: value and start-edge-to-valid latency.
      s0 = srv_n;
      t0 = cyc;
      fork
         send(1'b1, DIV_S, 8'hA5, 0);
         begin
            for (int k = 0; k < 13000 && srv_n == s0; k++) clks(1);
         end
      join
      lat = (srv_n == s0) ? -1 : srv_cyc - t0;
      chk_rng("a5_latency", lat, 11876, 11880);
      chk("a5_byte", int'(sbyte), 8'hA5);
      clks(100);
      chk("a5_pulse_count", srv_n - s0, 1);

      // Short glitch on the full-rate line is a false start.
      s0 = srv_n + sfe_n;
      rx_s = 1'b0;
      clks(400);
      rx_s = 1'b1;
      clks(2000);
      chk("glitch_full", srv_n + sfe_n - s0, 0);

      // Fast-rate latency.
      s0 = rv_n;
      t0 = cyc;
      fork
         send(1'b0, DIV_F, 8'h3C, 0);
         begin
            for (int k = 0; k < 400 && rv_n == s0; k++) clks(1);
         end
      join
      lat = (rv_n == s0) ? -1 : last_rv - t0;
      chk_rng("fast_latency", lat, 153, 157);
      chk("fast_byte", int'(last_byte), 8'h3C);
      clks(2 * DIV_F);

      // Stop bit held low for three bit times, then a clean 0x31.
      rv0 = rv_n;
      fe0 = fe_n;
      send(1'b0, DIV_F, 8'hF0, 3);
      clks(2 * DIV_F);
      chk("break_frame_err", fe_n - fe0, 1);
      chk("break_no_valid", rv_n - rv0, 0);
      chk("break_byte_kept", int'(rx_byte_f), 8'h3C);
      send(1'b0, DIV_F, 8'h31, 0);
      clks(2 * DIV_F);
      chk("after_break_byte", int'(last_byte), 8'h31);
      chk("after_break_valid", rv_n - rv0, 1);

      // Fast glitch.
      s0 = rv_n + fe_n + ce_n + tv_n;
      rx_f = 1'b0;
      clks(5);
      rx_f = 1'b1;
      clks(3 * DIV_F);
      chk("glitch_fast", rv_n + fe_n + ce_n + tv_n - s0, 0);

      // Command table.
      for (int i = 0; i < 10; i++) begin
         rv0 = rv_n;
         fe0 = fe_n;
         tv0 = tv_n;
         ce0 = ce_n;
         for (int j = 0; j < tbl[i].n; j++) begin
            b = tbl[i].s[8 * (tbl[i].n - 1 - j) +: 8];
            send(1'b0, DIV_F, b, 0);
         end
         if (tbl[i].ferr) send(1'b0, DIV_F, 8'h55, 1);
         clks(3 * DIV_F);
         chk($sformatf("row%0d_thr", i), int'(threshold_f), tbl[i].thr);
         chk($sformatf("row%0d_cmd_err", i), ce_n - ce0, tbl[i].ce);
         chk($sformatf("row%0d_thresh_valid", i), tv_n - tv0, tbl[i].tv);
         chk($sformatf("row%0d_rx_valid", i), rv_n - rv0, tbl[i].n);
         chk($sformatf("row%0d_frame_err", i), fe_n - fe0, int'(tbl[i].ferr));
      end

      // Reset in the middle of a command and a frame.
      send(1'b0, DIV_F, "T", 0);
      rx_f = 1'b0;
      clks(3 * DIV_F);
      rst = 1'b1;
      rx_f = 1'b1;
      clks(4);
      rst = 1'b0;
      clks(3 * DIV_F);
      chk("midframe_rst_thr", int'(threshold_f), 15);
      rv0 = rv_n;
      tv0 = tv_n;
      ce0 = ce_n;
      send(1'b0, DIV_F, 8'h41, 0);
      clks(2 * DIV_F);
      chk("post_rst_byte", int'(last_byte), 8'h41);
      chk("post_rst_valid", rv_n - rv0, 1);
      send(1'b0, DIV_F, "5", 0);
      send(1'b0, DIV_F, 8'h0D, 0);
      clks(3 * DIV_F);
      chk("post_rst_cmd_gone", int'(threshold_f), 15);
      chk("post_rst_no_pulse", tv_n - tv0 + ce_n - ce0, 0);

      // Randomised command streams against the model.
      m_in = 0;
      m_thr = 15;
      for (int i = 0; i < 16; i++) begin
         rv0 = rv_n;
         tv0 = tv_n;
         ce0 = ce_n;
         m_rv = 0;
         m_tv = 0;
         m_ce = 0;
         len = $urandom_range(1, 5);
         for (int j = 0; j <= len + 1; j++) begin
            r = $urandom_range(0, 15);
            if (j == 0) b = "T";
            else if (j == len + 1) b = ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A;
            else if (r < 2) b = (r == 0) ? "T" : "t";
            else if (r < 12) b = 8'($urandom_range(48, 57));
            else if (r == 12) b = "X";
            else if (r == 13) b = 8'h0D;
            else b = 8'($urandom_range(48, 57));
            if (j > 0 && j <= len && $urandom_range(0, 19) == 0) begin
               send(1'b0, DIV_F, 8'h55, 1);
               m_ferr();
            end
            send(1'b0, DIV_F, b, 0);
            m_byte(b);
         end
         clks(3 * DIV_F);
         chk($sformatf("rand%0d_thr", i), int'(threshold_f), m_thr);
         chk($sformatf("rand%0d_tv", i), tv_n - tv0, m_tv);
         chk($sformatf("rand%0d_ce", i), ce_n - ce0, m_ce);
         chk($sformatf("rand%0d_rv", i), rv_n - rv0, m_rv);
      end

      chk("pulse_rules_fast", viol, 0);
      chk("pulse_width_full", sviol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
